// File: rtl/picoctrl_pkg.sv
// Shared encodings for the PicoCtrl sequencer: instruction fields, action codes,
// state encoding and a decode helper used by the core and the ROM opcode include.
package picoctrl_pkg;

    localparam int INSTR_W      = 16;
    localparam int N_REGS       = 4;

    localparam int COND_SEL_MSB = 15;
    localparam int COND_SEL_LSB = 13;
    localparam int COND_POL_BIT = 12;
    localparam int ACT_MSB      = 11;
    localparam int ACT_LSB      = 10;
    localparam int REG_MSB      = 9;
    localparam int REG_LSB      = 8;
    localparam int DATA_MSB     = 7;
    localparam int DATA_LSB     = 0;

    typedef enum logic [1:0] {
        ACT_NOP   = 2'b00,
        ACT_WRITE = 2'b01,
        ACT_JUMP  = 2'b10,
        ACT_HALT  = 2'b11
    } action_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // {cond_sel, cond_pol}: c0 is tied low, so selecting it with polarity 0 always holds
    localparam logic [3:0] COND_ALWAYS = 4'b0000;

    typedef struct packed {
        logic [2:0] cond_sel;
        logic       cond_pol;
        action_e    action;
        logic [1:0] reg_sel;
        logic [7:0] data;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] word);
        instr_t d;
        d.cond_sel = word[COND_SEL_MSB:COND_SEL_LSB];
        d.cond_pol = word[COND_POL_BIT];
        d.action   = action_e'(word[ACT_MSB:ACT_LSB]);
        d.reg_sel  = word[REG_MSB:REG_LSB];
        d.data     = word[DATA_MSB:DATA_LSB];
        return d;
    endfunction

endpackage

// File: rtl/picoctrl_cond_sync.sv
// Two-flop synchronizer for the external condition inputs (used only when
// PICOCTRL_COND_SYNC_EN is defined).
module picoctrl_cond_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of asynchronous condition levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/picoctrl_core.sv
// PicoCtrl execution core: fetch from ROM, evaluate condition, write/jump/halt.
// Optional macro PICOCTRL_COND_SYNC_EN adds a 2-flop synchronizer on cond_in.
module picoctrl_core
    import picoctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int N_COND = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [INSTR_W-1:0]    rom_data,
    input  logic [N_COND-1:0]     cond_in,
    input  logic                  ce,
    input  logic                  start,
    output logic [4*DATA_W-1:0]   reg_out,
    output logic [3:0]            reg_wr,
    output logic                  halted
);

    localparam logic [N_COND-1:0] COND_MASK = {{(N_COND-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0]              pc_r;
    state_e                         state_r;
    logic [N_REGS-1:0][DATA_W-1:0]  regs_r;
    logic [N_REGS-1:0]              reg_wr_r;
    logic                           halted_r;

    logic [N_COND-1:0]              cond_raw_s;
    logic [N_COND-1:0]              cond_s;
    instr_t                         instr_s;
    logic                           take_s;
    logic [ADDR_W-1:0]              pc_inc_s;
    logic [ADDR_W-1:0]              next_pc_s;
    state_e                         next_state_s;
    logic [N_REGS-1:0]              wr_strobe_s;

    assign cond_raw_s = cond_in & COND_MASK;

`ifdef PICOCTRL_COND_SYNC_EN
    picoctrl_cond_sync #(
        .W (N_COND)
    ) u_cond_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cond_raw_s),
        .q     (cond_s)
    );
`else
    assign cond_s = cond_raw_s;
`endif

    assign instr_s  = decode_instr(rom_data);
    assign take_s   = (cond_s[instr_s.cond_sel] == instr_s.cond_pol);
    assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next PC, next state and write strobe for the instruction at PC
    always_comb begin
        next_pc_s    = pc_r;
        next_state_s = state_r;
        wr_strobe_s  = 4'b0000;
        case (state_r)
            ST_RUN: begin
                if (ce) begin
                    next_pc_s = pc_inc_s;
                    case (instr_s.action)
                        ACT_WRITE: begin
                            if (take_s) begin
                                wr_strobe_s[instr_s.reg_sel] = 1'b1;
                            end else begin
                                wr_strobe_s = 4'b0000;
                            end
                        end
                        ACT_JUMP: begin
                            if (take_s) begin
                                next_pc_s = instr_s.data[ADDR_W-1:0];
                            end else begin
                                next_pc_s = pc_inc_s;
                            end
                        end
                        ACT_HALT: begin
                            // A taken halt parks PC on the halt instruction itself
                            if (take_s) begin
                                next_pc_s    = pc_r;
                                next_state_s = ST_HALT;
                            end else begin
                                next_state_s = ST_RUN;
                            end
                        end
                        ACT_NOP: begin
                            next_pc_s = pc_inc_s;
                        end
                        default: begin
                            next_pc_s = pc_inc_s;
                        end
                    endcase
                end else begin
                    next_pc_s = pc_r;
                end
            end
            ST_HALT: begin
                if (ce && start) begin
                    next_pc_s    = {ADDR_W{1'b0}};
                    next_state_s = ST_RUN;
                end else begin
                    next_pc_s    = pc_r;
                end
            end
            default: begin
                next_pc_s    = {ADDR_W{1'b0}};
                next_state_s = ST_RUN;
            end
        endcase
    end

    // Sequencer state: PC, FSM state, halted flag and write strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= {ADDR_W{1'b0}};
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
            reg_wr_r <= 4'b0000;
        end else begin
            pc_r     <= next_pc_s;
            state_r  <= next_state_s;
            halted_r <= (next_state_s == ST_HALT);
            reg_wr_r <= wr_strobe_s;
        end
    end

    // Output registers, loaded only on a taken write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_r <= {(N_REGS*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (wr_strobe_s[i]) begin
                    regs_r[i] <= instr_s.data[DATA_W-1:0];
                end
            end
        end
    end

    assign rom_addr = pc_r;
    assign reg_out  = regs_r;
    assign reg_wr   = reg_wr_r;
    assign halted   = halted_r;

endmodule
